// File: rtl/led_pkg.sv
// Shared definitions for the memory-mapped LED controller: register map and CTRL field positions.
package led_pkg;

    typedef enum logic [1:0] {
        LED_A_VALUE  = 2'd0,
        LED_A_TOGGLE = 2'd1,
        LED_A_MASK   = 2'd2,
        LED_A_CTRL   = 2'd3
    } led_addr_e;

    localparam int DUTY_LSB = 24;
    localparam int DUTY_W   = 8;

endpackage

// File: rtl/led_blink_timer.sv
// Blink timebase: prescaler counts 0..period-1 and flips the phase on every wrap.
// A period of zero parks the timer with phase high so blinking LEDs stay lit.
module led_blink_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    output logic                phase
);

    logic [PERIOD_W-1:0] prescaler;
    logic                at_last;

    assign at_last = (prescaler == (period - PERIOD_W'(1)));

    // Prescaler and phase; a restart (CTRL write) takes priority over a coincident wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prescaler <= '0;
            phase     <= 1'b1;
        end else if (restart || (period == '0)) begin
            prescaler <= '0;
            phase     <= 1'b1;
        end else if (at_last) begin
            prescaler <= '0;
            phase     <= ~phase;
        end else begin
            prescaler <= prescaler + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/led_ctrl.sv
// MMIO LED output controller: VALUE / TOGGLE / BLINK_MASK / CTRL registers, registered LED drive.
// Optional dimming is compiled in when LED_CTRL_PWM_EN is defined (duty in CTRL[31:24]).
module led_ctrl
    import led_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PERIOD_W = 24
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [WIDTH-1:0] led
);

    logic [WIDTH-1:0]    value_q;
    logic [WIDTH-1:0]    mask_q;
    logic [PERIOD_W-1:0] period_q;
    logic                phase;
    logic                ctrl_wr;
    logic                dim_gate;
    logic [WIDTH-1:0]    led_next;

    // Upper store-data bits are legitimately ignored for narrow configurations.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    assign ctrl_wr = we && (addr == LED_A_CTRL);

    // Register file: VALUE, TOGGLE (xor into VALUE), BLINK_MASK and CTRL period.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            value_q  <= '0;
            mask_q   <= '0;
            period_q <= '0;
        end else if (we) begin
            case (led_addr_e'(addr))
                LED_A_VALUE:  value_q  <= wdata[WIDTH-1:0];
                LED_A_TOGGLE: value_q  <= value_q ^ wdata[WIDTH-1:0];
                LED_A_MASK:   mask_q   <= wdata[WIDTH-1:0];
                LED_A_CTRL:   period_q <= wdata[PERIOD_W-1:0];
                default:      value_q  <= value_q;
            endcase
        end
    end

    led_blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .period  (period_q),
        .restart (ctrl_wr),
        .phase   (phase)
    );

`ifdef LED_CTRL_PWM_EN
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] pwm_cnt;

    // Duty register and free-running PWM counter; CTRL writes never clear the counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            duty_q  <= '0;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + DUTY_W'(1);
            if (ctrl_wr) begin
                duty_q <= wdata[DUTY_LSB +: DUTY_W];
            end
        end
    end

    assign dim_gate = (duty_q == '0) || (pwm_cnt < duty_q);
`else
    assign dim_gate = 1'b1;
`endif

    // Output gating: masked LEDs go dark in the low blink phase, then optional dimming.
    always_comb begin
        led_next = value_q & ~(mask_q & {WIDTH{~phase}});
        if (!dim_gate) begin
            led_next = '0;
        end
    end

    // LED drive register, one cycle behind the register file.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led <= '0;
        end else begin
            led <= led_next;
        end
    end

    // Read-back mux; depends only on addr and current register contents.
    always_comb begin
        rdata = '0;
        case (led_addr_e'(addr))
            LED_A_VALUE, LED_A_TOGGLE: rdata[WIDTH-1:0]    = value_q;
            LED_A_MASK:                rdata[WIDTH-1:0]    = mask_q;
            LED_A_CTRL: begin
                rdata[PERIOD_W-1:0] = period_q;
`ifdef LED_CTRL_PWM_EN
                rdata[DUTY_LSB +: DUTY_W] = duty_q;
`endif
            end
            default:                   rdata = '0;
        endcase
    end

endmodule
